// File: rtl/sum_of_squares_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : sum_of_squares_pkg
//  Description : Shared types, default widths and width helper for the
//                vector-length front end (sum of squares feeding SquareRoot).
//  Revision    : 1.0 - initial release
// ============================================================================
package sum_of_squares_pkg;

  // Sequencer states: capture, three squaring passes, then hold the result
  typedef enum logic [2:0] {
    IDLE = 3'd0,
    SQ_X = 3'd1,
    SQ_Y = 3'd2,
    SQ_Z = 3'd3,
    DONE = 3'd4
  } sos_state_t;

  // Sum width for a given component width. The worst case is
  // 3 * 2^(2*in_w-2), which is below 2^(2*in_w), so 2*in_w bits suffice.
  function automatic int sos_out_w(input int in_w);
    return 2 * in_w;
  endfunction

  localparam int DEFAULT_IN_W  = 8;
  localparam int DEFAULT_OUT_W = sos_out_w(DEFAULT_IN_W);

endpackage : sum_of_squares_pkg
`default_nettype wire

// File: rtl/signed_square.sv
`default_nettype none
// ============================================================================
//  Module      : signed_square
//  Description : Combinational square of a two's-complement operand. The
//                result is returned as an unsigned 2*IN_W-bit value, which
//                is exact for every input including -2^(IN_W-1).
//  Revision    : 1.0 - initial release
// ============================================================================
module signed_square #(
  parameter int IN_W = 8
) (
  input  logic [IN_W-1:0]   a,
  output logic [2*IN_W-1:0] sq
);

  logic signed [2*IN_W-1:0] a_ext;
  logic signed [2*IN_W-1:0] prod;

  // Sign-extend to the product width so the truncated signed product is the
  // full square; the largest square 2^(2*IN_W-2) still fits as a positive value.
  always_comb begin
    a_ext = {{IN_W{a[IN_W-1]}}, a};
    prod  = a_ext * a_ext;
    sq    = prod;
  end

endmodule : signed_square
`default_nettype wire

// File: rtl/sum_of_squares.sv
`default_nettype none
// ============================================================================
//  Module      : sum_of_squares
//  Description : Accepts a signed (x, y, z) vector over valid/ready, forms
//                x^2 + y^2 + z^2 with one shared squarer over three cycles,
//                holds the result on a valid/ready output and pulses
//                sr_start once when the result becomes valid.
//  Revision    : 1.0 - initial release
// ============================================================================
module sum_of_squares
  import sum_of_squares_pkg::*;
#(
  parameter int IN_W  = DEFAULT_IN_W,
  parameter int OUT_W = sos_out_w(IN_W)
) (
  input  logic             clk,
  input  logic             rst_,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [IN_W-1:0]  in_x,
  input  logic [IN_W-1:0]  in_y,
  input  logic [IN_W-1:0]  in_z,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [OUT_W-1:0] out_sum,
  output logic             sr_start
);

  sos_state_t        state_q, state_d;
  logic [IN_W-1:0]   x_q, x_d;
  logic [IN_W-1:0]   y_q, y_d;
  logic [IN_W-1:0]   z_q, z_d;
  logic [OUT_W-1:0]  acc_q, acc_d;
  logic              out_valid_q, out_valid_d;
  logic              sr_start_q, sr_start_d;

  logic [IN_W-1:0]   sq_in;
  logic [2*IN_W-1:0] sq_out;
  logic [OUT_W-1:0]  sq_ext;

  // Route the captured operand for the current pass into the shared squarer
  always_comb begin
    sq_in = '0;
    case (state_q)
      SQ_X:    sq_in = x_q;
      SQ_Y:    sq_in = y_q;
      SQ_Z:    sq_in = z_q;
      default: sq_in = '0;
    endcase
  end

  signed_square #(
    .IN_W (IN_W)
  ) u_signed_square (
    .a  (sq_in),
    .sq (sq_out)
  );

  assign sq_ext = OUT_W'(sq_out);

  // Sequencer: next state, operand capture, accumulation and output flags
  always_comb begin
    state_d     = state_q;
    x_d         = x_q;
    y_d         = y_q;
    z_d         = z_q;
    acc_d       = acc_q;
    out_valid_d = out_valid_q;
    sr_start_d  = 1'b0;
    case (state_q)
      IDLE: begin
        if (in_valid) begin
          x_d     = in_x;
          y_d     = in_y;
          z_d     = in_z;
          acc_d   = '0;
          state_d = SQ_X;
        end
      end
      SQ_X: begin
        acc_d   = sq_ext;
        state_d = SQ_Y;
      end
      SQ_Y: begin
        acc_d   = acc_q + sq_ext;
        state_d = SQ_Z;
      end
      SQ_Z: begin
        acc_d       = acc_q + sq_ext;
        out_valid_d = 1'b1;
        sr_start_d  = 1'b1;
        state_d     = DONE;
      end
      DONE: begin
        if (out_ready) begin
          out_valid_d = 1'b0;
          state_d     = IDLE;
        end
      end
      default: begin
        out_valid_d = 1'b0;
        state_d     = IDLE;
      end
    endcase
  end

  // State and datapath registers; reset aborts any pass in flight
  always_ff @(posedge clk) begin
    if (rst_) begin
      state_q     <= IDLE;
      x_q         <= '0;
      y_q         <= '0;
      z_q         <= '0;
      acc_q       <= '0;
      out_valid_q <= 1'b0;
      sr_start_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      x_q         <= x_d;
      y_q         <= y_d;
      z_q         <= z_d;
      acc_q       <= acc_d;
      out_valid_q <= out_valid_d;
      sr_start_q  <= sr_start_d;
    end
  end

  assign in_ready  = (state_q == IDLE);
  assign out_valid = out_valid_q;
  assign out_sum   = acc_q;
  assign sr_start  = sr_start_q;

endmodule : sum_of_squares
`default_nettype wire

// File: tb/tb_sum_of_squares.sv
`default_nettype none
// ============================================================================
//  Module      : tb_sum_of_squares
//  Description : Directed self-checking bench for sum_of_squares.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_sum_of_squares;

  logic        clk = 1'b0;
  logic        rst_;
  logic        in_valid;
  logic        in_ready;
  logic [7:0]  in_x, in_y, in_z;
  logic        out_valid;
  logic        out_ready;
  logic [15:0] out_sum;
  logic        sr_start;

  int n_checks = 0;
  int n_errors = 0;
  int cyc      = 0;
  int acc_cyc  = 0;
  int prev_acc = 0;

  sum_of_squares #(
    .IN_W  (8),
    .OUT_W (16)
  ) dut (
    .clk       (clk),
    .rst_      (rst_),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_x      (in_x),
    .in_y      (in_y),
    .in_z      (in_z),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_sum   (out_sum),
    .sr_start  (sr_start)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // Present a vector, wait (bounded) for in_ready, and return just after the accept edge
  task automatic accept(input logic [7:0] x, input logic [7:0] y, input logic [7:0] z,
                        input bit keep_valid);
    int n;
    in_x = x; in_y = y; in_z = z; in_valid = 1'b1;
    n = 0;
    while (!in_ready && n < 20) begin
      @(posedge clk); #1; n++;
    end
    check("accept_ready", in_ready, 1);
    @(posedge clk);
    #1;
    acc_cyc = cyc;
    if (!keep_valid) in_valid = 1'b0;
  endtask

  // Wait (bounded) for out_valid after an accept; check latency, strobe and sum
  task automatic wait_out(input string tag, input logic [15:0] exp);
    int lat;
    lat = 0;
    while (!out_valid && lat < 10) begin
      @(posedge clk); #1; lat++;
    end
    check({tag, "_lat"}, lat, 3);
    check({tag, "_start"}, sr_start, 1);
    check(tag, out_sum, exp);
  endtask

  initial begin
    int pulses;
    int unstable;
    logic [15:0] exp_stream [4];
    logic [7:0]  vx [4];
    logic [7:0]  vy [4];
    logic [7:0]  vz [4];

    rst_ = 1'b1; in_valid = 1'b0; out_ready = 1'b0;
    in_x = '0; in_y = '0; in_z = '0;
    repeat (2) @(posedge clk);
    #1;
    // Reset state
    check("rst_in_ready", in_ready, 1);
    check("rst_out_valid", out_valid, 0);
    check("rst_sr_start", sr_start, 0);
    check("rst_out_sum", out_sum, 0);
    rst_ = 1'b0;

    // (3,4,0) -> 25, strobe one cycle only
    out_ready = 1'b1;
    accept(8'h03, 8'h04, 8'h00, 1'b0);
    wait_out("v345", 16'd25);
    @(posedge clk); #1;
    check("v345_start_one", sr_start, 0);
    check("v345_valid_drop", out_valid, 0);
    check("v345_idle", in_ready, 1);

    // (-128,-128,-128) -> 49152
    accept(8'h80, 8'h80, 8'h80, 1'b0);
    wait_out("vmin", 16'd49152);
    // (127,-128,0) -> 16129 + 16384 = 32513
    accept(8'h7F, 8'h80, 8'h00, 1'b0);
    wait_out("vmix", 16'd32513);

    // Backpressure: (1,2,2) -> 9, held for 10 cycles
    @(posedge clk); #1;
    out_ready = 1'b0;
    accept(8'h01, 8'h02, 8'h02, 1'b0);
    wait_out("vbp", 16'd9);
    pulses = 0; unstable = 0;
    repeat (10) begin
      @(posedge clk); #1;
      if (sr_start) pulses++;
      if (!out_valid || out_sum !== 16'd9 || in_ready) unstable++;
    end
    check("bp_extra_start", pulses, 0);
    check("bp_unstable", unstable, 0);
    out_ready = 1'b1;
    @(posedge clk); #1;
    check("bp_valid_drop", out_valid, 0);
    check("bp_in_ready", in_ready, 1);

    // Operand change after accept: (5,0,0) captured, x=100 ignored while busy
    accept(8'h05, 8'h00, 8'h00, 1'b1);
    prev_acc = acc_cyc;
    in_x = 8'd100;
    wait_out("vchg", 16'd25);
    @(posedge clk); #1;
    check("chg_idle_again", in_ready, 1);
    @(posedge clk); #1;
    check("chg_second_gap", cyc - prev_acc, 5);
    in_valid = 1'b0;
    wait_out("vchg2", 16'd10000);

    // Reset mid-op in SQ_Y: (10,10,10) is discarded
    @(posedge clk); #1;
    accept(8'h0A, 8'h0A, 8'h0A, 1'b0);
    @(posedge clk); #1;
    rst_ = 1'b1;
    @(posedge clk); #1;
    rst_ = 1'b0;
    check("mid_rst_valid", out_valid, 0);
    check("mid_rst_ready", in_ready, 1);
    pulses = 0;
    repeat (6) begin
      @(posedge clk); #1;
      if (sr_start || out_valid) pulses++;
    end
    check("mid_rst_no_start", pulses, 0);
    accept(8'h00, 8'h00, 8'h00, 1'b0);
    wait_out("vzero", 16'd0);
    @(posedge clk); #1;

    // Reset and in_valid on the same edge: nothing captured
    rst_ = 1'b1; in_valid = 1'b1;
    in_x = 8'h07; in_y = 8'h07; in_z = 8'h07;
    @(posedge clk); #1;
    rst_ = 1'b0; in_valid = 1'b0;
    check("rst_win_ready", in_ready, 1);
    repeat (4) @(posedge clk);
    #1;
    check("rst_win_no_valid", out_valid, 0);

    // Back-to-back stream with in_valid and out_ready held high
    vx[0] = 8'hFF; vy[0] = 8'h02; vz[0] = 8'hFD; exp_stream[0] = 16'd14;    // (-1,2,-3)
    vx[1] = 8'h64; vy[1] = 8'hCE; vz[1] = 8'h07; exp_stream[1] = 16'd12549; // (100,-50,7)
    vx[2] = 8'h81; vy[2] = 8'h00; vz[2] = 8'h01; exp_stream[2] = 16'd16130; // (-127,0,1)
    vx[3] = 8'h0C; vy[3] = 8'hF4; vz[3] = 8'h0C; exp_stream[3] = 16'd432;   // (12,-12,12)
    out_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      accept(vx[i], vy[i], vz[i], 1'b1);
      if (i > 0) check($sformatf("b2b_gap%0d", i), acc_cyc - prev_acc, 5);
      prev_acc = acc_cyc;
      wait_out($sformatf("b2b%0d", i), exp_stream[i]);
    end
    in_valid = 1'b0;
    repeat (3) @(posedge clk);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule : tb_sum_of_squares
`default_nettype wire
